// File: rtl/run_ctrl_if.sv
// Host/core handshake bundle for run_ctrl: host requests, core Start/Ack and run status.
// The master side drives requests and the core ack; the slave side is the sequencer.
interface run_ctrl_if #(
   parameter int CW = 16
);
   logic          HostStart;
   logic          HostClear;
   logic          CpuAck;
   logic          CpuStart;
   logic          Busy;
   logic          Done;
   logic          Timeout;
   logic [CW-1:0] CycleCt;
   logic [3:0]    RunCnt;

   modport master (
      output HostStart, HostClear, CpuAck,
      input  CpuStart, Busy, Done, Timeout, CycleCt, RunCnt
   );

   modport slave (
      input  HostStart, HostClear, CpuAck,
      output CpuStart, Busy, Done, Timeout, CycleCt, RunCnt
   );
endinterface

// File: rtl/run_ctrl.sv
// Program-run sequencer: launches the CPU core, counts run cycles, reports done/clear.
// Optional watchdog abort compiled in with `define RUN_CTRL_WATCHDOG_EN.
module run_ctrl #(
   parameter int          CW         = 16,
   parameter int          LAUNCH_CYC = 2,
   parameter int unsigned WD_LIMIT   = 32'h0000_FFFF
) (
   input logic         Clk,
   input logic         Reset_n,
   run_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
`ifdef RUN_CTRL_WATCHDOG_EN
      S_TIMEOUT,
`endif
      S_DONE
   } state_t;

   localparam logic [CW-1:0] CT_MAX      = '1;
   localparam logic [3:0]    LAUNCH_LOAD = 4'(LAUNCH_CYC - 1);

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_launch;
   logic [3:0]    w_launch_nxt;
   logic [CW-1:0] r_cycle;
   logic [CW-1:0] w_cycle_nxt;
   logic [3:0]    r_runs;
   logic [3:0]    w_runs_nxt;
   logic          r_cpu_start;
   logic          r_busy;
   logic          r_done;
   logic          w_cpu_start;
   logic          w_busy;
   logic          w_done;

`ifdef RUN_CTRL_WATCHDOG_EN
   localparam logic [CW-1:0] WD_THR = CW'(WD_LIMIT);
   logic r_timeout;
   logic w_timeout;
`else
   logic w_unused_wd;
   assign w_unused_wd = ^(CW'(WD_LIMIT));
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next       = r_state;
      w_launch_nxt = r_launch;
      w_cycle_nxt  = r_cycle;
      w_runs_nxt   = r_runs;
      case (r_state)
         S_IDLE: begin
            if (bus.HostStart) begin
               w_next       = S_LAUNCH;
               w_launch_nxt = LAUNCH_LOAD;
               w_cycle_nxt  = '0;
            end
         end
         S_LAUNCH: begin
            if (r_launch == 4'd0) w_next = S_RUN;
            else                  w_launch_nxt = r_launch - 4'd1;
         end
         S_RUN: begin
            // Ack beats the watchdog; the acking cycle itself is not counted.
            if (bus.CpuAck) begin
               w_next     = S_DONE;
               w_runs_nxt = r_runs + 4'd1;
            end
`ifdef RUN_CTRL_WATCHDOG_EN
            else if (r_cycle == WD_THR) begin
               w_next = S_TIMEOUT;
            end
`endif
            else if (r_cycle != CT_MAX) begin
               w_cycle_nxt = r_cycle + CW'(1);
            end
         end
         S_DONE: begin
            if (bus.HostClear) w_next = S_IDLE;
         end
`ifdef RUN_CTRL_WATCHDOG_EN
         S_TIMEOUT: begin
            if (bus.HostClear) w_next = S_IDLE;
         end
`endif
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered alongside it.
   always_comb begin
      w_busy      = (w_next == S_LAUNCH) || (w_next == S_RUN);
      w_done      = (w_next == S_DONE);
`ifdef RUN_CTRL_WATCHDOG_EN
      w_timeout   = (w_next == S_TIMEOUT);
      w_cpu_start = (w_next == S_LAUNCH) || (w_next == S_TIMEOUT);
`else
      w_cpu_start = (w_next == S_LAUNCH);
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state     <= S_IDLE;
         r_launch    <= '0;
         r_cycle     <= '0;
         r_runs      <= '0;
         r_cpu_start <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_launch    <= w_launch_nxt;
         r_cycle     <= w_cycle_nxt;
         r_runs      <= w_runs_nxt;
         r_cpu_start <= w_cpu_start;
         r_busy      <= w_busy;
         r_done      <= w_done;
      end
   end

`ifdef RUN_CTRL_WATCHDOG_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_timeout <= 1'b0;
      else          r_timeout <= w_timeout;
   end
   assign bus.Timeout = r_timeout;
`else
   assign bus.Timeout = 1'b0;
`endif

   assign bus.CpuStart = r_cpu_start;
   assign bus.Busy     = r_busy;
   assign bus.Done     = r_done;
   assign bus.CycleCt  = r_cycle;
   assign bus.RunCnt   = r_runs;

endmodule
